// File: rtl/game_round_sequencer.sv
// Round controller for the number-guessing game: arms rounds, captures guesses,
// enforces the tick timeout, scores by distance and declares the match champion.
module game_round_sequencer #(
  parameter int SIZE            = 6,
  parameter int TICKS_PER_ROUND = 50,
  parameter int WIN_SCORE       = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Tick,
  input  logic            Target_Valid,
  input  logic [SIZE-1:0] Target_Num,
  input  logic            First_Valid,
  input  logic [SIZE-1:0] First_Num,
  input  logic            Second_Valid,
  input  logic [SIZE-1:0] Second_Num,
  output logic [SIZE-1:0] Latched_Target,
  output logic [SIZE-1:0] Latched_First,
  output logic [SIZE-1:0] Latched_Second,
  output logic            Eval,
  output logic [1:0]      Round_Result,
  output logic            Round_Done,
  output logic [3:0]      Score_First,
  output logic [3:0]      Score_Second,
  output logic [7:0]      Round_Count,
  output logic            Match_Over,
  output logic [1:0]      Champion,
  output logic            Busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, COLLECT, EVAL, RESULT, DONE
  } state_t;

  state_t          state;
  logic [7:0]      tick_cnt;
  logic            got_first;
  logic            got_second;
  logic [SIZE-1:0] d_first;
  logic [SIZE-1:0] d_second;
  logic [1:0]      result;
  logic            timeout;

  assign timeout = Tick && (tick_cnt == 8'(TICKS_PER_ROUND - 1));

  // Larger minus smaller, so the distance never wraps.
  assign d_first  = (Latched_First >= Latched_Target) ?
                    Latched_First - Latched_Target :
                    Latched_Target - Latched_First;
  assign d_second = (Latched_Second >= Latched_Target) ?
                    Latched_Second - Latched_Target :
                    Latched_Target - Latched_Second;

  always_comb begin
    result = 2'b00;
    unique case ({got_first, got_second})
      2'b10: result = 2'b10;
      2'b01: result = 2'b01;
      2'b00: result = 2'b00;
      2'b11: begin
        if (d_first < d_second)      result = 2'b10;
        else if (d_second < d_first) result = 2'b01;
        else                         result = 2'b11;
      end
      default: result = 2'b00;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      got_first      <= 1'b0;
      got_second     <= 1'b0;
      Latched_Target <= '0;
      Latched_First  <= '0;
      Latched_Second <= '0;
      Eval           <= 1'b0;
      Round_Result   <= 2'b00;
      Round_Done     <= 1'b0;
      Score_First    <= '0;
      Score_Second   <= '0;
      Round_Count    <= '0;
      Match_Over     <= 1'b0;
      Champion       <= 2'b00;
      Busy           <= 1'b0;
    end else begin
      Eval       <= 1'b0;
      Round_Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            Score_First  <= '0;
            Score_Second <= '0;
            Round_Count  <= '0;
            Busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (Target_Valid) begin
            Latched_Target <= Target_Num;
            tick_cnt       <= '0;
            got_first      <= 1'b0;
            got_second     <= 1'b0;
            state          <= COLLECT;
          end
        end
        COLLECT: begin
          if (First_Valid && !got_first) begin
            Latched_First <= First_Num;
            got_first     <= 1'b1;
          end
          if (Second_Valid && !got_second) begin
            Latched_Second <= Second_Num;
            got_second     <= 1'b1;
          end
          if (Tick)
            tick_cnt <= tick_cnt + 8'd1;
          if ((got_first && got_second) || timeout) begin
            Eval  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          Round_Result <= result;
          if (result == 2'b10)
            Score_First <= Score_First + 4'd1;
          if (result == 2'b01)
            Score_Second <= Score_Second + 4'd1;
          if (Round_Count != 8'hFF)
            Round_Count <= Round_Count + 8'd1;
          Round_Done <= 1'b1;
          state      <= RESULT;
        end
        RESULT: begin
          if (Score_First == 4'(WIN_SCORE)) begin
            Champion   <= 2'b10;
            Match_Over <= 1'b1;
            Busy       <= 1'b0;
            state      <= DONE;
          end else if (Score_Second == 4'(WIN_SCORE)) begin
            Champion   <= 2'b01;
            Match_Over <= 1'b1;
            Busy       <= 1'b0;
            state      <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        DONE: begin
          if (Start) begin
            Score_First  <= '0;
            Score_Second <= '0;
            Round_Count  <= '0;
            Champion     <= 2'b00;
            Match_Over   <= 1'b0;
            Busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
Round controller for the number-guessing game. It arms a round, captures the target and both players' guesses, and enforces a guess timeout counted in divided-clock ticks. It scores each round by distance to the target, keeps the match score and declares a champion after WIN_SCORE round wins. It sits between the player/target input logic and the correlation/decision datapath, which it feeds with latched operands.

Parameters:
SIZE, 6, width of target and guess numbers
TICKS_PER_ROUND, 50, number of Tick pulses allowed for guessing (range 1..255)
WIN_SCORE, 3, round wins needed to take the match (range 1..15)

Ports:
Clock  input  1  system clock, 20 ns
Reset  input  1  synchronous, active-low reset
Start  input  1  begins a match; honoured only in IDLE and DONE
Tick  input  1  one-Clock enable pulse from the frequency divider
Target_Valid  input  1  Target_Num is valid this cycle
Target_Num  input  SIZE  round target
First_Valid  input  1  player 1 guess strobe
First_Num  input  SIZE  player 1 guess
Second_Valid  input  1  player 2 guess strobe
Second_Num  input  SIZE  player 2 guess
Latched_Target  output  SIZE  registered target for the datapath
Latched_First  output  SIZE  registered player 1 guess
Latched_Second  output  SIZE  registered player 2 guess
Eval  output  1  one-cycle pulse: latched operands are valid, evaluate now
Round_Result  output  2  10 = first wins, 01 = second wins, 11 = tie, 00 = no guesses
Round_Done  output  1  one-cycle pulse when Round_Result is updated
Score_First  output  4  player 1 round wins
Score_Second  output  4  player 2 round wins
Round_Count  output  8  rounds completed, saturates at 255
Match_Over  output  1  high in DONE
Champion  output  2  10 or 01 in DONE, else 00
Busy  output  1  high in every state except IDLE and DONE

Behaviour:
- Reset low at a rising edge: state = IDLE. Every output register and internal counter/flag is cleared to 0. Reset has priority over all inputs and over any round in progress.
- States: IDLE, LOAD, COLLECT, EVAL, RESULT, DONE. All outputs are registered.
- IDLE: when Start = 1, clear scores and Round_Count, then go to LOAD.
- LOAD: wait for Target_Valid. On Target_Valid, latch Latched_Target, clear the tick counter and the got_first/got_second flags, then go to COLLECT. Guess strobes are ignored in LOAD.
- COLLECT:
  - First_Valid with got_first = 0: latch First_Num and set got_first. Later strobes are ignored. Second_Valid works the same way for player 2.
  - Tick increments the tick counter.
  - Go to EVAL on the next edge after both flags are set, or when Tick arrives with tick counter = TICKS_PER_ROUND-1 (timeout).
  - A guess strobe in the same cycle as the timeout Tick is accepted.
  - Target_Valid is ignored.
- EVAL:
  - Eval = 1 for exactly this cycle.
  - dF = |Latched_First - Latched_Target| and dS = |Latched_Second - Latched_Target|, computed unsigned at SIZE bits with no wrap (larger minus smaller).
  - Result: only one player guessed → that player wins. Neither guessed → 00. Both guessed → smaller distance wins; equal distance → 11.
  - On the next edge: register Round_Result, add 1 to the winner's score (ties and 00 score nothing), increment Round_Count (saturating). Go to RESULT.
- RESULT: Round_Done = 1 for one cycle. If either score = WIN_SCORE, go to DONE with Champion set to that player; otherwise go to LOAD.
- DONE: Match_Over = 1. Scores, Champion and Round_Result hold. Start clears scores, Round_Count, Champion and Match_Over, then goes to LOAD.
- Start outside IDLE/DONE has no effect.
- Latency: with both guesses captured, Eval is asserted 1 cycle after the second capture, Round_Done 2 cycles after, and scores are visible together with Round_Done.
- Latched_* hold their values until the next capture.

Test Plan:
- Reset low mid-COLLECT → next cycle: Busy = 0, scores = 0, Round_Result = 00, state IDLE; a following Start is accepted.
- Start, target 20, First 18, Second 25 → Eval, then Round_Result = 10, Score_First = 1, Round_Done pulses once.
- Target 10, First 7, Second 13 → Round_Result = 11, scores unchanged, Round_Count incremented.
- TICKS_PER_ROUND = 4, only Second 40 given, then 4 Ticks → timeout, Round_Result = 01. Repeat with no guesses → Round_Result = 00.
- Duplicate First_Valid (5, then 60) with target 5 → Latched_First = 5. First_Valid coincident with the timeout Tick → guess accepted.
- WIN_SCORE = 3, player 1 wins three rounds → DONE, Match_Over = 1, Champion = 10. Start ignored while Busy; Start in DONE clears scores and enters LOAD.
